// File: rtl/ram_pkg.sv
// Shared definitions for the RAM initiator: default geometry, command
// opcodes, FSM states and small opcode decode helpers.
package ram_pkg;

  localparam int RAM_AW = 4;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_READ       = 2'b01,
    OP_FILL       = 2'b10,
    OP_BURST_READ = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10
  } state_t;

  // Bit 0 of the opcode selects read vs write.
  function automatic logic op_is_read(input logic [1:0] op);
    return op[0];
  endfunction

  // Bit 1 of the opcode selects a multi-beat burst (cmd_len is honoured).
  function automatic logic op_is_burst(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Two-stage read token pipeline. Stage 1 lines a {valid, addr, last} token
// up with the RAM's registered dout; stage 2 captures dout next to the token
// and presents the response. Runs independently of the command FSM.
module ram_rd_tag_pipe
  import ram_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic          issue_last,
  input  logic [DW-1:0] ram_dout,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last
);

  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic          s1_last;

  // Stage 1: hold the token for the cycle in which ram_dout carries its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= issue_valid;
      s1_addr  <= issue_valid ? issue_addr : '0;
      s1_last  <= issue_valid & issue_last;
    end
  end

  // Stage 2: capture dout alongside the token; idle slots present zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      rsp_valid <= s1_valid;
      rsp_data  <= s1_valid ? ram_dout : '0;
      rsp_addr  <= s1_valid ? s1_addr : '0;
      rsp_last  <= s1_valid & s1_last;
    end
  end

endmodule

// File: rtl/ram_initiator.sv
// Command-driven initiator for a single-port synchronous RAM with one cycle
// of read latency. Accepts single/burst read/write commands and drives the
// RAM port one beat per cycle; read data returns on a tagged response strobe.
//
// Command handshake: a command transfers on every rising edge where
// cmd_valid && cmd_ready are both high. cmd_ready is high only in IDLE (and
// not during reset). The issuer must hold cmd_* stable while cmd_valid is
// high and cmd_ready is low. Responses (rsp_*) have no ready: the consumer
// must take rsp_data/rsp_addr/rsp_last in the cycle rsp_valid is high.
module ram_initiator
  import ram_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          done,
  output state_t        dbg_state
);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;     // beats remaining after the current one
  logic [DW-1:0] data_q;
  logic          done_wr_q;
  logic          accept;
  logic          last_beat;

  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic [AW-1:0] pipe_addr;
  logic          pipe_last;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (cnt_q == '0);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: IDLE dispatches on the opcode, bursts run until the last beat.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = op_is_read(cmd_op) ? RD : WR;
      WR, RD:  if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/beat/data registers: load on accept, step once per active beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      addr_q <= cmd_addr;
      cnt_q  <= op_is_burst(cmd_op) ? cmd_len : '0;
      data_q <= cmd_data;
    end else if (state != IDLE) begin
      addr_q <= addr_q + 1'b1;          // wraps modulo 2^AW
      if (!last_beat) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Write completion pulses in the first IDLE cycle after the final beat.
  always_ff @(posedge clk) begin
    if (rst) done_wr_q <= 1'b0;
    else     done_wr_q <= (state == WR) && last_beat;
  end

  // RAM port: zero when idle or in reset so the bus is quiet between bursts.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      if (state == WR) begin
        ram_we   = 1'b1;
        ram_addr = addr_q;
        ram_din  = data_q;
      end else if (state == RD) begin
        ram_addr = addr_q;
      end
    end
  end

  ram_rd_tag_pipe #(
    .AW(AW),
    .DW(DW)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (state == RD),
    .issue_addr  (addr_q),
    .issue_last  (last_beat),
    .ram_dout    (ram_dout),
    .rsp_valid   (pipe_valid),
    .rsp_data    (pipe_data),
    .rsp_addr    (pipe_addr),
    .rsp_last    (pipe_last)
  );

  // Responses are forced quiet while reset is held.
  always_comb begin
    rsp_valid = pipe_valid & !rst;
    rsp_data  = rst ? '0 : pipe_data;
    rsp_addr  = rst ? '0 : pipe_addr;
    rsp_last  = pipe_last & !rst;
    done      = (done_wr_q | (pipe_valid & pipe_last)) & !rst;
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator driving a 16 x 8 synchronous RAM model.
module tb_ram_initiator;
  import ram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int EW = AW + DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          done;
  state_t        dbg_state;

  logic [DW-1:0] mem [16] = '{default: 8'h00};

  int pass_cnt = 0;
  int total_cnt = 0;
  int rsp_cnt = 0;
  int hs_cnt = 0;

  logic [EW-1:0] exp_q[$];

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT + RAM model ----------------
  ram_initiator #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_last(rsp_last), .done(done), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every response must match the head of the expected queue.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) hs_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_addr", {28'd0, rsp_addr}, {28'd0, e[EW-1 -: AW]});
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e[DW:1]});
        check("rsp_last", {31'd0, rsp_last}, {31'd0, e[0]});
        check("rsp_done", {31'd0, done}, {31'd0, e[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns #1 into the first beat cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr,
                          input logic [3:0] len, input logic [7:0] data);
    int n;
    n = 0;
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("exp_q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic push_exp(input logic [3:0] addr, input logic [7:0] data, input logic last);
    exp_q.push_back({addr, data, last});
  endtask

  function automatic logic [31:0] all_outs();
    return {3'd0, cmd_ready, ram_we, ram_addr, ram_din, rsp_valid, rsp_data,
            rsp_addr, rsp_last, done};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int base;
    int n;
    logic [3:0] a;

    // Reset: every output low while rst is held.
    repeat (3) tick();
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // WRITE addr=3 data=A5.
    send_cmd(OP_WRITE, 4'd3, 4'd0, 8'hA5);
    check("wr_we", {31'd0, ram_we}, 32'd1);
    check("wr_addr", {28'd0, ram_addr}, 32'd3);
    check("wr_din", {24'd0, ram_din}, 32'hA5);
    check("wr_busy", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("wr_done", {30'd0, cmd_ready, done}, 32'd3);
    check("mem3", {24'd0, mem[3]}, 32'hA5);

    // READ addr=3: response exactly 3 cycles after accept.
    push_exp(4'd3, 8'hA5, 1'b1);
    send_cmd(OP_READ, 4'd3, 4'd0, 8'h00);
    check("rd_addr", {28'd0, ram_addr}, 32'd3);
    tick();
    check("rd_c2_quiet", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("rd_c3_rsp", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'hA5});
    check("rd_c3_tag", {26'd0, rsp_addr, rsp_last, done}, {26'd0, 4'd3, 1'b1, 1'b1});
    tick();
    check("rd_c4_quiet", {31'd0, rsp_valid}, 32'd0);
    wait_drain();

    // FILL addr=14 len=3 data=5C, wrapping past 15.
    send_cmd(OP_FILL, 4'd14, 4'd3, 8'h5C);
    for (int i = 0; i < 4; i++) begin
      a = 4'd14 + 4'(i);
      check("fill_beat", {19'd0, ram_we, ram_addr, ram_din}, {19'd0, 1'b1, a, 8'h5C});
      tick();
    end
    check("fill_done", {30'd0, cmd_ready, done}, 32'd3);
    check("mem14", {24'd0, mem[14]}, 32'h5C);
    check("mem15", {24'd0, mem[15]}, 32'h5C);
    check("mem0", {24'd0, mem[0]}, 32'h5C);
    check("mem1", {24'd0, mem[1]}, 32'h5C);
    check("mem2_untouched", {24'd0, mem[2]}, 32'h00);

    // BURST_READ addr=14 len=3.
    push_exp(4'd14, 8'h5C, 1'b0);
    push_exp(4'd15, 8'h5C, 1'b0);
    push_exp(4'd0, 8'h5C, 1'b0);
    push_exp(4'd1, 8'h5C, 1'b1);
    send_cmd(OP_BURST_READ, 4'd14, 4'd3, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 4'd14 + 4'(i);
      tick();
      check("brd_seq", {26'd0, rsp_valid, rsp_addr, rsp_last},
            {26'd0, 1'b1, a, (i == 3)});
    end
    wait_drain();
    wait_ready();

    // mem[i] = i, then a full 16-beat burst read.
    for (int i = 0; i < 16; i++) begin
      send_cmd(OP_WRITE, 4'(i), 4'd0, 8'(i));
      wait_ready();
    end
    for (int i = 0; i < 16; i++) push_exp(4'(i), 8'(i), (i == 15));
    send_cmd(OP_BURST_READ, 4'd0, 4'd15, 8'h00);
    tick();
    check("b16_c2_quiet", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("b16_valid_done", {30'd0, rsp_valid, done}, {30'd0, 1'b1, (i == 15)});
    end
    tick();
    check("b16_after_quiet", {31'd0, rsp_valid}, 32'd0);
    wait_drain();
    wait_ready();

    // BURST_READ len=1 then WRITE at the first IDLE cycle.
    push_exp(4'd15, 8'h0F, 1'b0);
    push_exp(4'd0, 8'h00, 1'b1);
    send_cmd(OP_BURST_READ, 4'd15, 4'd1, 8'h00);
    tick();
    tick();
    check("ovl_ready_c3", {30'd0, cmd_ready, rsp_valid}, 32'd3);
    send_cmd(OP_WRITE, 4'd0, 4'd0, 8'hFF);
    check("ovl_wr_beat", {19'd0, ram_we, ram_addr, ram_din}, {19'd0, 1'b1, 4'd0, 8'hFF});
    wait_drain();
    wait_ready();
    tick();
    check("ovl_mem0", {24'd0, mem[0]}, 32'hFF);

    // Reset during beat 3 of BURST_READ addr=0 len=7.
    base = rsp_cnt;
    send_cmd(OP_BURST_READ, 4'd0, 4'd7, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_outs", all_outs(), 32'd0);
    tick();
    check("mid_rst_outs2", all_outs(), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (12) tick();
    check("post_rst_no_rsp", rsp_cnt - base, 32'd0);

    // cmd_valid held through a 4-beat FILL; the next command lands once.
    base = hs_cnt;
    cmd_op = OP_FILL; cmd_addr = 4'd8; cmd_len = 4'd3; cmd_data = 8'h33;
    cmd_valid = 1'b1;
    tick();
    cmd_op = OP_WRITE; cmd_addr = 4'd9; cmd_len = 4'd0; cmd_data = 8'h77;
    n = 0;
    while (!cmd_ready && n < 20) begin
      n++;
      tick();
    end
    check("held_busy_cycles", n, 32'd4);
    tick();
    check("held_wr_beat", {19'd0, ram_we, ram_addr, ram_din}, {19'd0, 1'b1, 4'd9, 8'h77});
    cmd_valid = 1'b0;
    tick();
    check("held_idle", {30'd0, cmd_ready, ram_we}, 32'd2);
    repeat (3) tick();
    check("held_accepts", hs_cnt - base, 32'd2);
    check("held_mem8", {24'd0, mem[8]}, 32'h33);
    check("held_mem9", {24'd0, mem[9]}, 32'h77);
    check("held_mem11", {24'd0, mem[11]}, 32'h33);

    check("final_exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
# ram_initiator

Command-driven initiator for the 16 x 8 single-port synchronous RAM (write-enable, address, data-in, registered data-out). It sits between a control unit and the RAM. It accepts single or burst read/write commands over a valid/ready handshake and drives the RAM port cycle by cycle. It also tracks the RAM's one-cycle read latency and returns read data on a response strobe tagged with the address.

## Interface
- AW, 4, RAM address width (2^AW locations)
- DW, 8, RAM data width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL (burst write), 11 BURST_READ
- cmd_addr  in  AW  start address
- cmd_len  in  AW  beats minus one (FILL/BURST_READ only; ignored for WRITE/READ)
- cmd_data  in  DW  write data (WRITE, FILL)
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM registered read data
- rsp_valid  out  1  one-cycle read-data strobe, no backpressure
- rsp_data  out  DW  read data
- rsp_addr  out  AW  address the data came from
- rsp_last  out  1  final beat of a read command
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, WR, RD.
- IDLE:
  - cmd_ready=1, ram_we=0, ram_addr=0, ram_din=0.
  - A handshake (cmd_valid&&cmd_ready at an edge) loads the address register, beat counter and data.
  - The FSM then goes to WR (op[0]=0) or RD (op[0]=1).
- Beat count is cmd_len+1 for FILL/BURST_READ and 1 for WRITE/READ. Maximum is 16 beats.
- WR state:
  - Each cycle drives ram_we=1, ram_addr=addr, ram_din=data. FILL writes the same cmd_data to every beat.
  - Address increments modulo 2^AW, so 15 wraps to 0.
  - After the final beat the FSM returns to IDLE and done pulses in that first IDLE cycle.
- RD state:
  - Each cycle drives ram_we=0, ram_addr=addr and pushes a read token {addr, last} into a 2-stage tag pipeline.
  - Address wraps as in WR. After the final beat the FSM returns to IDLE.
- Tag pipeline:
  - Stage 1 aligns the token with ram_dout.
  - Stage 2 registers ram_dout into rsp_data and drives rsp_valid, rsp_addr and rsp_last.
  - done pulses together with rsp_last=1.
- The pipeline runs independently of the FSM. A new command may be accepted in the first IDLE cycle while earlier read responses are still draining. The RAM does not update dout on write cycles, so in-flight data stays intact.
- cmd_ready=0 in WR and RD. Commands are never dropped and never queued.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Tag pipeline tokens are cleared, so no rsp_valid is emitted for reads issued before reset.
  - A burst interrupted by reset is abandoned. Locations already written stay written.

## Timing
- The accept edge is at the end of cycle 0, and the first RAM beat is in cycle 1. Beats are back-to-back, one per cycle, with no bubbles.
- Write of N beats:
  - RAM beats occur in cycles 1..N.
  - cmd_ready and done are high in cycle N+1.
  - The next command can be accepted at the edge ending cycle N+1.
- Read beat issued in cycle k:
  - ram_dout is valid in cycle k+1.
  - rsp_valid is high in cycle k+2.
  - Single READ: rsp_valid in cycle 3.
  - BURST_READ of N beats: rsp_valid in cycles 3..N+2, rsp_last and done in cycle N+2.
- Command throughput: N+1 cycles per command. Back-to-back commands leave one IDLE cycle between bursts.
- rsp_valid is never backpressured. The consumer must sample it in the cycle it is high.

## Structure
- Shared package ram_pkg:
  - op encodings OP_WRITE, OP_READ, OP_FILL, OP_BURST_READ
  - defaults RAM_AW=4, RAM_DW=8
  - state enum {IDLE, WR, RD}
- One sub-module is natural: ram_rd_tag_pipe, the 2-stage {valid, addr, last} token pipeline with the registered rsp_data capture.
- The FSM, beat counter and address counter stay in ram_initiator.
- The bench instantiates ram_initiator connected to the team's 16 x 8 RAM model.

## Test plan
- Reset, then WRITE addr=3 data=0xA5, then READ addr=3 -> rsp_valid one cycle, 3 cycles after accept, with rsp_data=0xA5, rsp_addr=3, rsp_last=1, done=1.
- FILL addr=14 len=3 data=0x5C, then BURST_READ addr=14 len=3:
  - Locations 14, 15, 0, 1 hold 0x5C and location 2 is untouched (wrap check).
  - rsp_addr sequence is 14, 15, 0, 1 on consecutive cycles, with rsp_last only on the fourth beat.
- BURST_READ addr=0 len=15 after writing mem[i]=i -> 16 consecutive rsp_valid cycles with data 0x00..0x0F, and done on the 16th.
- BURST_READ len=1 accepted at the first IDLE cycle, followed immediately by WRITE addr=0 data=0xFF -> both read responses arrive unchanged, and mem[0]=0xFF afterwards.
- rst asserted in the middle of BURST_READ addr=0 len=7, during beat 3 -> no rsp_valid in any cycle after reset, cmd_ready=1 in the first cycle after rst deasserts, and all outputs are 0 during reset.
- cmd_valid held high through a 4-beat FILL -> cmd_ready low for exactly 4 cycles, and the second command is accepted exactly once.
